// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory with valid/ready fetch, RD_WAIT read wait states and a program-load port.
// Optional even-parity protection per word is enabled with INSTR_MEM_PARITY_EN.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 16,
    parameter int                RD_WAIT  = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'b00111000100000000000000000000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic [1:0]               rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
`ifdef INSTR_MEM_PARITY_EN
    input  logic                     ld_par_flip,
`endif
    output logic                     busy
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BYTES);
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MW = DATA_W + 1;
`else
    localparam int unsigned MW = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t            state, state_nx;
    logic              rdy_en;
    logic [CW-1:0]     cnt;
    logic [MW-1:0]     mem [DEPTH];
    logic              accept;
    logic              misal, oor, par_err;
    logic [IW-1:0]     idx;
    logic [MW-1:0]     rd_word;
    logic [DATA_W-1:0] res_instr;
    logic [1:0]        res_err;

    // Fetch decode evaluated in the accept cycle and captured into the response register.
    always_comb begin
        idx     = IW'(req_addr >> OFF);
        rd_word = mem[idx];
        misal   = (req_addr & ADDR_W'(BYTES - 1)) != '0;
        oor     = {1'b0, req_addr} >= LIMIT;
`ifdef INSTR_MEM_PARITY_EN
        par_err = ^rd_word;
`else
        par_err = 1'b0;
`endif
        if (misal)        res_err = 2'b01;
        else if (oor)     res_err = 2'b10;
        else if (par_err) res_err = 2'b11;
        else              res_err = 2'b00;
        res_instr = (res_err != 2'b00) ? NOP_WORD : rd_word[DATA_W-1:0];
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rdy_en && !ld_en;
                if (req_valid && req_ready)
                    state_nx = (RD_WAIT > 0) ? WAIT : RESP;
            end
            WAIT:    if (cnt == CW'(RD_WAIT - 1)) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        accept = req_valid && req_ready;
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // rdy_en keeps req_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy_en    <= 1'b0;
            cnt       <= '0;
            rsp_instr <= '0;
            rsp_err   <= '0;
        end else begin
            state  <= state_nx;
            rdy_en <= 1'b1;
            if (accept) begin
                cnt       <= '0;
                rsp_instr <= res_instr;
                rsp_err   <= res_err;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en) begin
`ifdef INSTR_MEM_PARITY_EN
            mem[ld_addr] <= {(^ld_data) ^ ld_par_flip, ld_data};
`else
            mem[ld_addr] <= ld_data;
`endif
        end
    end

endmodule
